// File: rtl/rcn2avalon_if.sv
// Signal bundle between the rcn ring slave node and its environment: ring in/out plus the Avalon-MM master side.
// The node uses the master modport; the ring/Avalon slave environment uses the slave modport.
interface rcn2avalon_if;
    logic [68:0] rcn_in;
    logic [68:0] rcn_out;
    logic [21:0] av_address;
    logic        av_write;
    logic        av_read;
    logic [3:0]  av_byteenable;
    logic [31:0] av_writedata;
    logic        av_waitrequest;
    logic [31:0] av_readdata;
    logic        av_readdatavalid;

    modport master (
        input  rcn_in, av_waitrequest, av_readdata, av_readdatavalid,
        output rcn_out, av_address, av_write, av_read, av_byteenable, av_writedata
    );

    modport slave (
        output rcn_in, av_waitrequest, av_readdata, av_readdatavalid,
        input  rcn_out, av_address, av_write, av_read, av_byteenable, av_writedata
    );
endinterface

// File: rtl/rcn2avalon.sv
// rcn ring slave node: claims requests in its address window, replays each as one Avalon-MM
// transaction and re-inserts the completion into the first empty ring slot.
module rcn2avalon #(
    parameter logic [21:0] ADDR_MASK = 22'h000000,
    parameter logic [21:0] ADDR_BASE = 22'h000000
) (
    input  logic         clk,
    input  logic         rst,
    rcn2avalon_if.master bus
);
    typedef enum logic [1:0] {IDLE, AV_REQ, AV_RD, RESP} state_t;

    state_t      r_state, w_state_nxt;
    logic [68:0] r_rin;
    logic [68:0] r_rcn_out, w_rcn_out_nxt;
    logic        r_wr, w_wr_nxt;
    logic [5:0]  r_id, w_id_nxt;
    logic [3:0]  r_mask, w_mask_nxt;
    logic [21:0] r_addr, w_addr_nxt;
    logic [1:0]  r_seq, w_seq_nxt;
    logic [31:0] r_data, w_data_nxt;
    logic        r_av_read, w_av_read_nxt;
    logic        r_av_write, w_av_write_nxt;
    logic [31:0] r_av_wdata, w_av_wdata_nxt;
    logic        w_match;

    // Only pending requests (not responses) inside the window are claimed.
    assign w_match = r_rin[68] & r_rin[67] & ((r_rin[55:34] & ADDR_MASK) == ADDR_BASE);

    always_comb begin
        w_state_nxt    = r_state;
        w_rcn_out_nxt  = r_rin;
        w_wr_nxt       = r_wr;
        w_id_nxt       = r_id;
        w_mask_nxt     = r_mask;
        w_addr_nxt     = r_addr;
        w_seq_nxt      = r_seq;
        w_data_nxt     = r_data;
        w_av_read_nxt  = r_av_read;
        w_av_write_nxt = r_av_write;
        w_av_wdata_nxt = r_av_wdata;
        case (r_state)
            IDLE: begin
                if (w_match) begin
                    w_wr_nxt       = r_rin[66];
                    w_id_nxt       = r_rin[65:60];
                    w_mask_nxt     = r_rin[59:56];
                    w_addr_nxt     = r_rin[55:34];
                    w_seq_nxt      = r_rin[33:32];
                    w_data_nxt     = r_rin[31:0];
                    w_av_wdata_nxt = r_rin[31:0];
                    w_av_read_nxt  = ~r_rin[66];
                    w_av_write_nxt = r_rin[66];
                    w_rcn_out_nxt  = '0;
                    w_state_nxt    = AV_REQ;
                end
            end
            AV_REQ: begin
                if (!bus.av_waitrequest) begin
                    w_av_read_nxt  = 1'b0;
                    w_av_write_nxt = 1'b0;
                    w_state_nxt    = r_wr ? RESP : AV_RD;
                end
            end
            AV_RD: begin
                if (bus.av_readdatavalid) begin
                    w_data_nxt  = bus.av_readdata;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                // Insert only into an empty slot so no circulating word is lost.
                if (!r_rin[68]) begin
                    w_rcn_out_nxt = {1'b1, 1'b0, r_wr, r_id, r_mask, r_addr, r_seq, r_data};
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_rin      <= '0;
            r_rcn_out  <= '0;
            r_wr       <= 1'b0;
            r_id       <= '0;
            r_mask     <= '0;
            r_addr     <= '0;
            r_seq      <= '0;
            r_data     <= '0;
            r_av_read  <= 1'b0;
            r_av_write <= 1'b0;
            r_av_wdata <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rin      <= bus.rcn_in;
            r_rcn_out  <= w_rcn_out_nxt;
            r_wr       <= w_wr_nxt;
            r_id       <= w_id_nxt;
            r_mask     <= w_mask_nxt;
            r_addr     <= w_addr_nxt;
            r_seq      <= w_seq_nxt;
            r_data     <= w_data_nxt;
            r_av_read  <= w_av_read_nxt;
            r_av_write <= w_av_write_nxt;
            r_av_wdata <= w_av_wdata_nxt;
        end
    end

    assign bus.rcn_out       = r_rcn_out;
    assign bus.av_address    = r_addr;
    assign bus.av_byteenable = r_mask;
    assign bus.av_writedata  = r_av_wdata;
    assign bus.av_read       = r_av_read;
    assign bus.av_write      = r_av_write;
endmodule

// File: tb/tb_rcn2avalon.sv
// Bench for rcn2avalon: window is word addresses 0x000000..0x00FFFF; a transaction-level model
// predicts ring and Avalon outputs every cycle, and directed scenarios pin exact timing with literals.
module tb_rcn2avalon;
    logic clk;
    logic rst;
    rcn2avalon_if bus();

    rcn2avalon #(.ADDR_MASK(22'h3F0000), .ADDR_BASE(22'h000000)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [68:0] mk(input logic wr, input logic [5:0] id, input logic [3:0] mask,
                                       input logic [21:0] addr, input logic [1:0] seq, input logic [31:0] data);
        return {1'b1, 1'b1, wr, id, mask, addr, seq, data};
    endfunction

    function automatic bit claimable(input logic [68:0] w);
        return w[68] && w[67] && (w[55:34] < 22'h010000);
    endfunction

    // Avalon slave behaviour, configurable per scenario.
    int          cfg_wait  = 0;
    int          cfg_rdd   = 1;
    bit          cfg_spur  = 0;
    bit          cfg_fix   = 0;
    logic [31:0] cfg_rdata = '0;
    int          wait_left = -1;
    int          rd_delay  = 0;

    initial begin
        bus.av_waitrequest   = 1'b0;
        bus.av_readdatavalid = 1'b0;
        bus.av_readdata      = '0;
        forever begin
            @(negedge clk);
            bus.av_readdatavalid = 1'b0;
            if (rd_delay > 0) begin
                rd_delay--;
                if (rd_delay == 0) begin
                    bus.av_readdatavalid = 1'b1;
                    bus.av_readdata      = cfg_fix ? cfg_rdata : $urandom;
                end
            end else if (cfg_spur && $urandom_range(0, 7) == 0) begin
                bus.av_readdatavalid = 1'b1;
                bus.av_readdata      = $urandom;
            end
            if (bus.av_read || bus.av_write) begin
                if (wait_left < 0) wait_left = (cfg_wait < 0) ? int'($urandom_range(0, 3)) : cfg_wait;
                if (wait_left > 0) begin
                    bus.av_waitrequest = 1'b1;
                    wait_left--;
                end else begin
                    bus.av_waitrequest = 1'b0;
                    wait_left = -1;
                    if (bus.av_read) rd_delay = (cfg_rdd < 0) ? int'($urandom_range(1, 4)) : cfg_rdd;
                end
            end else begin
                wait_left = -1;
                bus.av_waitrequest = cfg_spur ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // Transaction-level model: one outstanding job, response waits for an empty slot.
    bit          m_valid = 0, m_busy = 0, m_cmd = 0, m_rdwait = 0, m_ready = 0;
    logic [68:0] m_h1 = '0, m_req = '0, m_exp_out = '0;
    logic [31:0] m_rdata = '0;
    int          n_resp = 0;

    initial begin : model
        logic [68:0] nxt;
        bit ins, clm;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid = 1; m_busy = 0; m_cmd = 0; m_rdwait = 0; m_ready = 0;
                m_exp_out = '0; m_h1 = '0;
            end else begin
                ins = m_ready && !m_h1[68];
                clm = !m_busy && claimable(m_h1);
                nxt = m_h1;
                if (clm) nxt = '0;
                else if (ins) begin
                    nxt = {2'b10, m_req[66:32], m_rdata};
                    n_resp++;
                end
                if (m_cmd && !bus.av_waitrequest) begin
                    m_cmd = 0;
                    if (m_req[66]) begin m_ready = 1; m_rdata = m_req[31:0]; end
                    else m_rdwait = 1;
                end else if (m_rdwait && bus.av_readdatavalid) begin
                    m_rdwait = 0; m_ready = 1; m_rdata = bus.av_readdata;
                end
                if (ins) begin m_ready = 0; m_busy = 0; end
                if (clm) begin m_busy = 1; m_cmd = 1; m_req = m_h1; end
                m_exp_out = nxt;
                m_h1 = bus.rcn_in;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("rcn_out", bus.rcn_out, m_exp_out);
                chk("av_read", 69'(bus.av_read), 69'(m_cmd & ~m_req[66]));
                chk("av_write", 69'(bus.av_write), 69'(m_cmd & m_req[66]));
                if (m_cmd) begin
                    chk("av_address", 69'(bus.av_address), 69'(m_req[55:34]));
                    chk("av_byteenable", 69'(bus.av_byteenable), 69'(m_req[59:56]));
                    chk("av_writedata", 69'(bus.av_writedata), 69'(m_req[31:0]));
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Directed scenario driver: stim[k] is on rcn_in in cycle k, obs_*[k] are outputs in cycle k.
    logic [68:0] stim [0:39];
    bit          stim_rst [0:39];
    logic [68:0] obs_out [0:39];
    bit          obs_rd [0:39];
    bit          obs_wr [0:39];
    logic [21:0] obs_addr [0:39];
    logic [3:0]  obs_be [0:39];
    logic [31:0] obs_wd [0:39];

    task automatic clear_stim();
        for (int i = 0; i < 40; i++) begin
            stim[i] = '0;
            stim_rst[i] = 0;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            obs_out[k]  = bus.rcn_out;
            obs_rd[k]   = bus.av_read;
            obs_wr[k]   = bus.av_write;
            obs_addr[k] = bus.av_address;
            obs_be[k]   = bus.av_byteenable;
            obs_wd[k]   = bus.av_writedata;
            bus.rcn_in  = stim[k];
            rst         = stim_rst[k];
        end
        clear_stim();
    endtask

    initial begin
        logic [68:0] w;
        logic [95:0] junk;
        int cnt;
        bus.rcn_in = '0;
        rst = 1'b1;
        clear_stim();
        repeat (3) @(negedge clk);
        chk("reset rcn_out", bus.rcn_out, 69'd0);
        chk("reset av_read", 69'(bus.av_read), 69'd0);
        chk("reset av_write", 69'(bus.av_write), 69'd0);
        chk("reset av_address", 69'(bus.av_address), 69'd0);
        chk("reset av_byteenable", 69'(bus.av_byteenable), 69'd0);
        chk("reset av_writedata", 69'(bus.av_writedata), 69'd0);
        rst = 1'b0;
        run(4);

        // Read, zero wait, readdatavalid two cycles after the strobe.
        cfg_wait = 0; cfg_rdd = 2; cfg_fix = 1; cfg_rdata = 32'hDEADBEEF;
        stim[0] = mk(1'b0, 6'h3F, 4'hF, 22'h000010, 2'd1, 32'h0);
        run(10);
        cnt = 0;
        for (int k = 0; k < 10; k++) cnt += int'(obs_rd[k]);
        chk("read strobe cycles", 69'(cnt), 69'd1);
        chk("read strobe cycle 2", 69'(obs_rd[2]), 69'd1);
        chk("read address", 69'(obs_addr[2]), 69'h10);
        chk("read response", obs_out[6], {1'b1, 1'b0, 1'b0, 6'h3F, 4'hF, 22'h000010, 2'd1, 32'hDEADBEEF});

        // Write with waitrequest held for three cycles.
        cfg_wait = 3;
        stim[0] = mk(1'b1, 6'h05, 4'h3, 22'h000020, 2'd2, 32'hCAFE1234);
        run(12);
        cnt = 0;
        for (int k = 0; k < 12; k++) cnt += int'(obs_wr[k]);
        chk("write strobe cycles", 69'(cnt), 69'd4);
        for (int k = 2; k < 6; k++) begin
            chk("write strobe held", 69'(obs_wr[k]), 69'd1);
            chk("writedata stable", 69'(obs_wd[k]), 69'hCAFE1234);
            chk("byteenable stable", 69'(obs_be[k]), 69'h3);
        end
        chk("claimed slot emptied", obs_out[2], 69'd0);
        chk("write response", obs_out[7], {1'b1, 1'b0, 1'b1, 6'h05, 4'h3, 22'h000020, 2'd2, 32'hCAFE1234});

        // Non-matching request and an in-window response pass straight through.
        cfg_wait = 0;
        stim[0] = mk(1'b0, 6'h11, 4'hF, 22'h010000, 2'd0, 32'h12345678);
        stim[1] = {1'b1, 1'b0, 1'b1, 6'h22, 4'hF, 22'h000004, 2'd3, 32'h0BADF00D};
        w = stim[1];
        run(8);
        chk("non-match pass", obs_out[2], mk(1'b0, 6'h11, 4'hF, 22'h010000, 2'd0, 32'h12345678));
        chk("response pass", obs_out[3], w);
        cnt = 0;
        for (int k = 0; k < 8; k++) cnt += int'(obs_rd[k]) + int'(obs_wr[k]);
        chk("no strobe on pass", 69'(cnt), 69'd0);

        // Busy drop-through and blocked insertion.
        cfg_rdd = 3; cfg_rdata = 32'h600DF00D;
        stim[0] = mk(1'b0, 6'h01, 4'hF, 22'h000100, 2'd0, 32'h0);
        stim[2] = mk(1'b1, 6'h02, 4'hC, 22'h000200, 2'd3, 32'hABCD0000);
        for (int k = 5; k < 10; k++) stim[k] = {1'b1, 1'b0, 35'(k), 32'($urandom)};
        for (int k = 0; k < 16; k++) obs_out[k] = stim[k];
        for (int k = 0; k < 16; k++) obs_addr[k] = '0;
        begin
            logic [68:0] saved [0:15];
            for (int k = 0; k < 16; k++) saved[k] = stim[k];
            run(16);
            chk("busy request forwarded", obs_out[4], saved[2]);
            for (int k = 7; k < 12; k++) chk("foreign word kept", obs_out[k], saved[k - 2]);
        end
        chk("blocked response inserted", obs_out[12], {1'b1, 1'b0, 1'b0, 6'h01, 4'hF, 22'h000100, 2'd0, 32'h600DF00D});
        cfg_fix = 0;
        run(4);

        // Reset while the write is stalled.
        cfg_wait = 20;
        stim[0] = mk(1'b1, 6'h0A, 4'hF, 22'h000040, 2'd0, 32'h55AA55AA);
        stim_rst[4] = 1;
        run(30);
        chk("write up before reset", 69'(obs_wr[3]), 69'd1);
        chk("write dropped by reset", 69'(obs_wr[5]), 69'd0);
        chk("rcn_out after reset", obs_out[5], 69'd0);
        cnt = 0;
        for (int k = 0; k < 30; k++) cnt += int'(obs_out[k][68]);
        chk("no response after reset", 69'(cnt), 69'd0);
        cfg_wait = 0;
        stim[0] = mk(1'b1, 6'h0B, 4'h5, 22'h000044, 2'd1, 32'h13579BDF);
        run(8);
        chk("fresh write strobe", 69'(obs_wr[2]), 69'd1);
        chk("fresh write response", obs_out[4], {1'b1, 1'b0, 1'b1, 6'h0B, 4'h5, 22'h000044, 2'd1, 32'h13579BDF});

        // Randomised ring traffic and slave timing.
        cfg_wait = -1; cfg_rdd = -1; cfg_spur = 1;
        cnt = n_resp;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 599) == 0);
            junk = {$urandom, $urandom, $urandom};
            case ($urandom_range(0, 9))
                0, 1, 2: w = '0;
                3:       w = {1'b0, junk[67:0]};
                4:       begin w = junk[68:0]; w[68] = 1'b1; w[67] = 1'b0; end
                5, 6:    w = mk(1'($urandom), 6'($urandom), 4'($urandom),
                                {6'($urandom_range(1, 63)), 16'($urandom)}, 2'($urandom), $urandom);
                default: w = mk(1'($urandom), 6'($urandom), 4'($urandom),
                                {6'd0, 16'($urandom)}, 2'($urandom), $urandom);
            endcase
            bus.rcn_in = w;
        end
        @(negedge clk);
        bus.rcn_in = '0;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("random responses seen", 69'(n_resp - cnt > 50), 69'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
